ypbpr_to_rgb: RTL and testbench

// - Inverse of the RGB->YPbPr output encoder: converts 8-bit Y/Pb/Pr (Pb/Pr offset 128) back to 8-bit RGB.
// - Sits on the analog-video capture/loopback path: loopback verification, and an upstream YPbPr source feeding the RGB scaler.
// - Fixed 3-cycle pipeline. hsync/vsync/csync/de are delayed to stay aligned with the pixels.
// - Bypass mode passes din unchanged with the same latency. The mode changes only at a frame boundary, so no frame is ever torn.

---
 rtl/vid_color_pkg.sv | 46 ++++
 rtl/vid_delay_line.sv | 25 ++
 rtl/ypbpr_to_rgb.sv | 131 +++++++++++++
 tb/tb_ypbpr_to_rgb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vid_color_pkg.sv
// Shared colour-space constants and pixel packing for the YPbPr encoder/decoder pair.
// The coefficients are fixed-point values with FRAC fraction bits.
package vid_color_pkg;

  localparam int unsigned FRAC       = 8;
  localparam int unsigned CHROMA_OFS = 128;

  // Accumulator: signed 19 bits. The largest sum is 65280+58112+128, so it cannot overflow.
  typedef logic signed [18:0] acc_t;
  typedef logic signed [8:0]  chroma_t;

  localparam acc_t YPB_KR  = 19'sd359;
  localparam acc_t YPB_KGB = 19'sd88;
  localparam acc_t YPB_KGR = 19'sd183;
  localparam acc_t YPB_KB  = 19'sd454;

  localparam int unsigned PIX_FW     = 8;
  localparam int unsigned PIX_HI_LSB = 16;
  localparam int unsigned PIX_MD_LSB = 8;
  localparam int unsigned PIX_LO_LSB = 0;

  typedef struct packed {
    logic [PIX_FW-1:0] pr;
    logic [PIX_FW-1:0] y;
    logic [PIX_FW-1:0] pb;
  } ypbpr_t;

  typedef struct packed {
    logic [PIX_FW-1:0] r;
    logic [PIX_FW-1:0] g;
    logic [PIX_FW-1:0] b;
  } rgb_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DECODE = 1'b1
  } mode_e;

  // The value must already be scaled down by FRAC. This saturates it to the 0..255 range.
  function automatic logic [7:0] clamp_u8(input acc_t v);
    if (v[18])              return 8'd0;
    else if (v > 19'sd255)  return 8'd255;
    else                    return v[7:0];
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth register delay line with an asynchronous active-low clear.
module vid_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/ypbpr_to_rgb.sv
// Converts 8-bit YPbPr (Pb/Pr offset 128) to 8-bit RGB through a fixed 3-stage pipeline.
// Bypass mode is supported. The mode is switched only at a vsync boundary, so no frame is torn.
module ypbpr_to_rgb #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned FRAC    = 8,
  parameter logic        VS_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ypbpr_en,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        csync_i,
  input  logic        de_i,
  input  logic [23:0] din,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o,
  output logic        de_o,
  output logic        mode_o
);
  import vid_color_pkg::*;

  localparam acc_t RND = acc_t'(1) <<< (FRAC - 1);

  // Frame-boundary mode FSM
  logic  r_vs_prev;
  mode_e r_mode_q;
  logic  w_vs_edge;
  mode_e w_mode_nxt;

  assign w_vs_edge  = (vsync_i == VS_POL) && (r_vs_prev != VS_POL);
  // The pixel sampled on the boundary cycle already carries the newly sampled mode.
  assign w_mode_nxt = w_vs_edge ? mode_e'(ypbpr_en) : r_mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_prev <= 1'b0;
      r_mode_q  <= MODE_BYPASS;
    end else begin
      r_vs_prev <= vsync_i;
      case (r_mode_q)
        MODE_BYPASS: if (w_vs_edge && ypbpr_en)  r_mode_q <= MODE_DECODE;
        MODE_DECODE: if (w_vs_edge && !ypbpr_en) r_mode_q <= MODE_BYPASS;
        default:     r_mode_q <= MODE_BYPASS;
      endcase
    end
  end

  // Stage 1: chroma offset removal and partial products
  ypbpr_t  w_in;
  chroma_t w_cb, w_cr;
  acc_t    w_y256;

  assign w_in   = din;
  assign w_cb   = chroma_t'({1'b0, w_in.pb}) - chroma_t'(CHROMA_OFS);
  assign w_cr   = chroma_t'({1'b0, w_in.pr}) - chroma_t'(CHROMA_OFS);
  assign w_y256 = acc_t'({11'd0, w_in.y}) <<< FRAC;

  acc_t  r_y256, r_p_r, r_p_gb, r_p_gr, r_p_b;
  acc_t  r_sum_r, r_sum_g, r_sum_b;
  mode_e r_mode1, r_mode2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y256  <= '0;
      r_p_r   <= '0;
      r_p_gb  <= '0;
      r_p_gr  <= '0;
      r_p_b   <= '0;
      r_mode1 <= MODE_BYPASS;
    end else begin
      r_y256  <= w_y256;
      r_p_r   <= acc_t'(w_cr) * YPB_KR;
      r_p_gb  <= acc_t'(w_cb) * YPB_KGB;
      r_p_gr  <= acc_t'(w_cr) * YPB_KGR;
      r_p_b   <= acc_t'(w_cb) * YPB_KB;
      r_mode1 <= w_mode_nxt;
    end
  end

  // Stage 2: sum the products and the rounding constant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
      r_mode2 <= MODE_BYPASS;
    end else begin
      r_sum_r <= r_y256 + r_p_r + RND;
      r_sum_g <= r_y256 - r_p_gb - r_p_gr + RND;
      r_sum_b <= r_y256 + r_p_b + RND;
      r_mode2 <= r_mode1;
    end
  end

  // Stage 3: scale down, clamp, then select decoded or bypassed pixel
  logic [23:0] w_din_d2;
  rgb_t        w_rgb;

  vid_delay_line #(.WIDTH(24), .DEPTH(LATENCY - 1)) u_din_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (din),
    .o_q     (w_din_d2)
  );

  assign w_rgb.r = clamp_u8(r_sum_r >>> FRAC);
  assign w_rgb.g = clamp_u8(r_sum_g >>> FRAC);
  assign w_rgb.b = clamp_u8(r_sum_b >>> FRAC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout   <= '0;
      mode_o <= 1'b0;
    end else begin
      dout   <= (r_mode2 == MODE_DECODE) ? w_rgb : w_din_d2;
      mode_o <= r_mode2;
    end
  end

  // Syncs travel separately. de does not gate the pixel data.
  vid_delay_line #(.WIDTH(4), .DEPTH(LATENCY)) u_sync_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({hsync_i, vsync_i, csync_i, de_i}),
    .o_q     ({hsync_o, vsync_o, csync_o, de_o})
  );

endmodule

// File: tb/tb_ypbpr_to_rgb.sv
// Bench for ypbpr_to_rgb. Directed and random pixels are checked against an arithmetic
// reference model with frame-boundary mode tracking and a 3-deep expected-output queue.
module tb_ypbpr_to_rgb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ypbpr_en = 1'b0;
  logic        hsync_i = 1'b0, vsync_i = 1'b0, csync_i = 1'b0, de_i = 1'b0;
  logic [23:0] din = '0;
  logic [23:0] dout;
  logic        hsync_o, vsync_o, csync_o, de_o, mode_o;

  always #5 clk = ~clk;

  ypbpr_to_rgb #(.LATENCY(3), .FRAC(8), .VS_POL(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ypbpr_en (ypbpr_en),
    .hsync_i  (hsync_i),
    .vsync_i  (vsync_i),
    .csync_i  (csync_i),
    .de_i     (de_i),
    .din      (din),
    .dout     (dout),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .csync_o  (csync_o),
    .de_o     (de_o),
    .mode_o   (mode_o)
  );

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  s;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic m_prev_vs = 1'b0;
  logic m_mode = 1'b0;

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Direct evaluation of the conversion equations in integer arithmetic.
  function automatic logic [23:0] decode(input logic [23:0] p);
    int y, cb, cr;
    logic [7:0] rr, gg, bb;
    y  = int'(p[15:8]);
    cb = int'(p[7:0]) - 128;
    cr = int'(p[23:16]) - 128;
    rr = 8'(clamp8((256*y + 359*cr + 128) >>> 8));
    gg = 8'(clamp8((256*y - 88*cb - 183*cr + 128) >>> 8));
    bb = 8'(clamp8((256*y + 454*cb + 128) >>> 8));
    return {rr, gg, bb};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    m_prev_vs = 1'b0;
    m_mode    = 1'b0;
  endtask

  // Drives one pixel, clocks it in, and checks the output that belongs to the pixel 3 cycles earlier.
  task automatic step(input logic [23:0] d, input logic en, input logic hs, input logic vs,
                      input logic cs, input logic de, input logic ovr = 1'b0,
                      input logic [23:0] xv = 24'h0);
    exp_t e, f;
    din = d; ypbpr_en = en; hsync_i = hs; vsync_i = vs; csync_i = cs; de_i = de;
    if (vs && !m_prev_vs) m_mode = en;
    m_prev_vs = vs;
    e.d = m_mode ? (ovr ? xv : decode(d)) : d;
    e.s = {hs, vs, cs, de};
    e.m = m_mode;
    q.push_back(e);
    @(posedge clk);
    #1;
    f = q.pop_front();
    chk("dout", dout, f.d);
    chk("sync", {20'd0, hsync_o, vsync_o, csync_o, de_o}, {20'd0, f.s});
    chk("mode", {23'd0, mode_o}, {23'd0, f.m});
  endtask

  task automatic rnd_step(input logic en, input logic vs);
    step($urandom(), en, 1'($urandom()), vs, 1'($urandom()), 1'($urandom()));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 24'h0);
    chk({tag, "_sync"}, {20'd0, hsync_o, vsync_o, csync_o, de_o}, 24'h0);
    chk({tag, "_mode"}, {23'd0, mode_o}, 24'h0);
  endtask

  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 0 in bypass. An ypbpr_en pulse mid-frame must be ignored.
    step(24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rnd_step(1'b0, 1'b0);
    rnd_step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) rnd_step(1'b0, 1'b0);

    // Boundary with en=1 switches to decode. Then the directed pixels.
    rnd_step(1'b1, 1'b1);
    step(24'h808080, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h808080);
    step(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h008800);
    // G = (65280 - 11176 - 23241 + 128) >> 8 = 30991 >> 8 = 121
    step(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFF79FF);
    for (int i = 0; i < 10; i++) rnd_step(1'(i & 1), 1'b0);

    // On the boundary cycle itself, the ypbpr_en value sampled on that cycle decides the mode.
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rnd_step(1'b1, 1'b1);
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) rnd_step(1'b1, 1'b0);

    // Random syncs, modes and pixels, with occasional vsync edges.
    for (int i = 0; i < 300; i++)
      rnd_step(1'($urandom()), ($urandom_range(0, 7) == 0) ? ~vsync_i : vsync_i);

    // Reset asserted between clock edges while in decode mode.
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) rnd_step(1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    reset_model();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) rnd_step(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
